pipe_ex_mc: RTL and testbench

Parametrised execute stage for the pipelined CPU: an ID→EX pipeline register, a WIDTH-bit ALU/shifter with immediate and shift-amount operand muxes, and an optional iterative multiplier that stalls the upstream pipeline while it runs. It sits between the decode stage and the EX/MEM register and supports flushes for branch recovery. Single-cycle ops complete one cycle after capture. Multiply ops complete WIDTH+1 cycles after capture.

---
 rtl/pipe_ex_mc.sv | 154 +++++++++++++++
 tb/tb_pipe_ex_mc.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ex_mc.sv
// Execute stage: ID->EX stage register, ALU/shifter with operand muxes,
// and an optional radix-2 shift-add multiplier that stalls upstream while busy.
//
// Handshake: stall_o-style backpressure via `stall`. While stall=1 the
// stage does not sample the ID inputs and upstream must hold them stable;
// when stall=0 every rising edge captures the ID inputs (unless flushed).
module pipe_ex_mc #(
  parameter int WIDTH  = 32,
  parameter int RA     = 5,
  parameter int MUL_EN = 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             IDwreg,
  input  logic             IDm2reg,
  input  logic             IDwmem,
  input  logic [3:0]       IDaluc,
  input  logic             IDshift,
  input  logic             IDaluimm,
  input  logic [RA-1:0]    IDwn,
  input  logic [WIDTH-1:0] IDqa,
  input  logic [WIDTH-1:0] IDqb,
  input  logic [WIDTH-1:0] IDimmeOrSa,
  input  logic             flush,
  output logic             stall,
  output logic             EXwreg,
  output logic             EXm2reg,
  output logic             EXwmem,
  output logic [RA-1:0]    EXwn,
  output logic [WIDTH-1:0] EXaluResult,
  output logic [WIDTH-1:0] EXdi,
  output logic [1:0]       dbg_state_o
);

  localparam int LG = $clog2(WIDTH);
  localparam logic [LG-1:0] CNT_LAST = LG'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Operand muxes in front of the stage register
  logic [WIDTH-1:0] a_d, b_d;
  logic             is_mul_id;

  // Stage register S
  logic [WIDTH-1:0] a_q, b_q, di_q;
  logic [3:0]       aluc_q;
  logic             wreg_q, m2reg_q, wmem_q;
  logic [RA-1:0]    wn_q;

  // Multiplier state
  state_t             state_q;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [LG-1:0]      cnt_q;
  logic [WIDTH:0]     step_sum;

  logic [WIDTH-1:0] alu_res;
  logic [LG-1:0]    sa;

  assign a_d = IDshift ? {{(WIDTH-LG){1'b0}}, IDimmeOrSa[LG-1:0]} : IDqa;
  assign b_d = IDaluimm ? IDimmeOrSa : IDqb;
  assign is_mul_id = (MUL_EN != 0) && ((IDaluc == 4'b1000) || (IDaluc == 4'b1100));

  assign stall = (MUL_EN != 0) && (state_q == ST_RUN);

  // Stage register: clear on clr/flush, load when not stalled, else hold
  always_ff @(posedge clk) begin
    if (clr || flush) begin
      a_q     <= '0;
      b_q     <= '0;
      di_q    <= '0;
      aluc_q  <= '0;
      wreg_q  <= 1'b0;
      m2reg_q <= 1'b0;
      wmem_q  <= 1'b0;
      wn_q    <= '0;
    end else if (!stall) begin
      a_q     <= a_d;
      b_q     <= b_d;
      di_q    <= IDqb;
      aluc_q  <= IDaluc;
      wreg_q  <= IDwreg;
      m2reg_q <= IDm2reg;
      wmem_q  <= IDwmem;
      wn_q    <= IDwn;
    end
  end

  // One shift-add step: add multiplicand into the upper half when the
  // current multiplier bit is set, then shift the whole accumulator right.
  always_comb begin
    step_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
    acc_d    = {step_sum, acc_q[WIDTH-1:1]};
  end

  // Multiplier FSM: IDLE/DONE accept a new op, RUN iterates WIDTH steps
  always_ff @(posedge clk) begin
    if (clr || flush) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + LG'(1);
          if (cnt_q == CNT_LAST) state_q <= ST_DONE;
        end
        default: begin
          if (is_mul_id) begin
            state_q <= ST_RUN;
            acc_q   <= {{WIDTH{1'b0}}, b_d};
            cnt_q   <= '0;
          end else begin
            state_q <= ST_IDLE;
          end
        end
      endcase
    end
  end

  // ALU / shifter on the stage register contents
  always_comb begin
    alu_res = '0;
    sa      = a_q[LG-1:0];
    case (aluc_q)
      4'b0000: alu_res = a_q + b_q;
      4'b0100: alu_res = a_q - b_q;
      4'b0001: alu_res = a_q & b_q;
      4'b0101: alu_res = a_q | b_q;
      4'b0010: alu_res = a_q ^ b_q;
      4'b0110: alu_res = b_q << (WIDTH / 2);
      4'b0011: alu_res = b_q << sa;
      4'b0111: alu_res = b_q >> sa;
      4'b1111: alu_res = $signed(b_q) >>> sa;
      4'b1000: alu_res = (MUL_EN != 0) ? acc_q[WIDTH-1:0] : '0;
      4'b1100: alu_res = (MUL_EN != 0) ? acc_q[2*WIDTH-1:WIDTH] : '0;
      default: alu_res = '0;
    endcase
  end

  // Write enables are suppressed until a running multiply has finished
  assign EXwreg      = wreg_q & ~stall;
  assign EXwmem      = wmem_q & ~stall;
  assign EXm2reg     = m2reg_q;
  assign EXwn        = wn_q;
  assign EXdi        = di_q;
  assign EXaluResult = alu_res;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_pipe_ex_mc.sv
// Bench for pipe_ex_mc: a 32-bit multiplier build and a 16-bit build
// without the multiplier, checked against a plain-arithmetic result model.
module tb_pipe_ex_mc;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  // ---------------- 32-bit, multiplier enabled ----------------
  logic        IDwreg, IDm2reg, IDwmem, IDshift, IDaluimm, flush;
  logic [3:0]  IDaluc;
  logic [4:0]  IDwn;
  logic [31:0] IDqa, IDqb, IDimmeOrSa;
  logic        stall, EXwreg, EXm2reg, EXwmem;
  logic [4:0]  EXwn;
  logic [31:0] EXaluResult, EXdi;
  logic [1:0]  dbg_state;

  pipe_ex_mc #(.WIDTH(32), .RA(5), .MUL_EN(1)) dut (
    .clk(clk), .clr(clr),
    .IDwreg(IDwreg), .IDm2reg(IDm2reg), .IDwmem(IDwmem),
    .IDaluc(IDaluc), .IDshift(IDshift), .IDaluimm(IDaluimm),
    .IDwn(IDwn), .IDqa(IDqa), .IDqb(IDqb), .IDimmeOrSa(IDimmeOrSa),
    .flush(flush), .stall(stall),
    .EXwreg(EXwreg), .EXm2reg(EXm2reg), .EXwmem(EXwmem),
    .EXwn(EXwn), .EXaluResult(EXaluResult), .EXdi(EXdi),
    .dbg_state_o(dbg_state)
  );

  // ---------------- 16-bit, multiplier disabled ----------------
  logic        n_wreg, n_m2reg, n_wmem, n_shift, n_aluimm, n_flush;
  logic [3:0]  n_aluc;
  logic [4:0]  n_wn;
  logic [15:0] n_qa, n_qb, n_imm;
  logic        n_stall, n_exwreg, n_exm2reg, n_exwmem;
  logic [4:0]  n_exwn;
  logic [15:0] n_res, n_di;
  logic [1:0]  n_dbg;

  pipe_ex_mc #(.WIDTH(16), .RA(5), .MUL_EN(0)) dut16 (
    .clk(clk), .clr(clr),
    .IDwreg(n_wreg), .IDm2reg(n_m2reg), .IDwmem(n_wmem),
    .IDaluc(n_aluc), .IDshift(n_shift), .IDaluimm(n_aluimm),
    .IDwn(n_wn), .IDqa(n_qa), .IDqb(n_qb), .IDimmeOrSa(n_imm),
    .flush(n_flush), .stall(n_stall),
    .EXwreg(n_exwreg), .EXm2reg(n_exm2reg), .EXwmem(n_exwmem),
    .EXwn(n_exwn), .EXaluResult(n_res), .EXdi(n_di),
    .dbg_state_o(n_dbg)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  // ---------------- reference model ----------------
  function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    int unsigned sa;
    p  = 64'(a) * 64'(b);
    sa = a % 32;
    case (op)
      4'd0:  return a + b;
      4'd4:  return a - b;
      4'd1:  return a & b;
      4'd5:  return a | b;
      4'd2:  return a ^ b;
      4'd6:  return b * 32'h0001_0000;
      4'd3:  return b << sa;
      4'd7:  return b >> sa;
      4'd15: return b[31] ? ~((~b) >> sa) : (b >> sa);
      4'd8:  return p[31:0];
      4'd12: return p[63:32];
      default: return 32'd0;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [3:0] op, input logic sh, input logic ai,
                        input logic [31:0] qa, input logic [31:0] qb, input logic [31:0] imm,
                        input logic wr, input logic m2, input logic wm, input logic [4:0] wn);
    IDaluc = op; IDshift = sh; IDaluimm = ai;
    IDqa = qa; IDqb = qb; IDimmeOrSa = imm;
    IDwreg = wr; IDm2reg = m2; IDwmem = wm; IDwn = wn;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    clr = 1'b1; flush = 1'b0; n_flush = 1'b0;
    set_op(4'd0, 1'b0, 1'b0, 32'd2, 32'd3, 32'd9, 1'b1, 1'b1, 1'b1, 5'd7);
    n_aluc = 4'd0; n_shift = 1'b0; n_aluimm = 1'b0; n_qa = 16'd5; n_qb = 16'd6;
    n_imm = 16'd1; n_wreg = 1'b1; n_m2reg = 1'b1; n_wmem = 1'b1; n_wn = 5'd3;
    tick(); tick();
    n_checks++;
    if ({stall, EXwreg, EXm2reg, EXwmem, EXwn, EXaluResult, EXdi} !== 72'd0) begin
      n_fail++;
      $display("FAIL reset32 got stall=%0b wreg=%0b m2reg=%0b wmem=%0b wn=%0d res=%h di=%h want all 0",
               stall, EXwreg, EXm2reg, EXwmem, EXwn, EXaluResult, EXdi);
    end
    n_checks++;
    if ({n_stall, n_exwreg, n_exm2reg, n_exwmem, n_exwn, n_res, n_di} !== 41'd0) begin
      n_fail++;
      $display("FAIL reset16 got stall=%0b res=%h di=%h want all 0", n_stall, n_res, n_di);
    end
    n_checks++;
    if (dbg_state !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_state got %0d want 0", dbg_state);
    end
    clr = 1'b0;
    tick();
    n_checks++;
    if (EXaluResult !== 32'd5) begin
      n_fail++;
      $display("FAIL first_capture got %h want 00000005", EXaluResult);
    end
  endtask

  task automatic test_back_to_back();
    set_op(4'd0, 1'b0, 1'b0, 32'd2, 32'd3, 32'd0, 1'b1, 1'b0, 1'b0, 5'd4);
    tick();
    n_checks++;
    if ({EXaluResult, EXdi, EXwreg, EXwn} !== {32'd5, 32'd3, 1'b1, 5'd4}) begin
      n_fail++;
      $display("FAIL b2b_add1 got res=%h di=%h wreg=%0b wn=%0d want 5 3 1 4", EXaluResult, EXdi, EXwreg, EXwn);
    end
    set_op(4'd0, 1'b0, 1'b0, 32'd4, 32'd7, 32'd0, 1'b0, 1'b0, 1'b1, 5'd9);
    tick();
    n_checks++;
    if ({EXaluResult, EXdi, EXwreg, EXwmem, EXwn} !== {32'd11, 32'd7, 1'b0, 1'b1, 5'd9}) begin
      n_fail++;
      $display("FAIL b2b_add2 got res=%h di=%h wreg=%0b wmem=%0b wn=%0d want 11 7 0 1 9",
               EXaluResult, EXdi, EXwreg, EXwmem, EXwn);
    end
  endtask

  task automatic test_mux_shift();
    set_op(4'd4, 1'b0, 1'b0, 32'd2, 32'd3, 32'd0, 1'b1, 1'b0, 1'b0, 5'd1);
    tick();
    n_checks++;
    if (EXaluResult !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL sub got %h want ffffffff", EXaluResult);
    end
    set_op(4'd15, 1'b1, 1'b0, 32'd0, 32'h8000_0000, 32'd4, 1'b1, 1'b0, 1'b0, 5'd2);
    tick();
    n_checks++;
    if (EXaluResult !== 32'hF800_0000) begin
      n_fail++;
      $display("FAIL sra got %h want f8000000", EXaluResult);
    end
    set_op(4'd6, 1'b0, 1'b1, 32'd0, 32'd0, 32'h0000_1234, 1'b1, 1'b0, 1'b0, 5'd3);
    tick();
    n_checks++;
    if (EXaluResult !== 32'h1234_0000) begin
      n_fail++;
      $display("FAIL lui got %h want 12340000", EXaluResult);
    end
  endtask

  task automatic test_mul(input logic [3:0] op, input logic [31:0] want);
    int n;
    set_op(op, 1'b0, 1'b0, 32'h0001_0000, 32'h0003_0001, 32'd0, 1'b1, 1'b0, 1'b0, 5'd5);
    tick();
    n = 0;
    while (stall === 1'b1 && n < 100) begin
      n_checks++;
      if (EXwreg !== 1'b0) begin
        n_fail++;
        $display("FAIL mul_wreg_during_stall op=%0d cycle=%0d got %0b want 0", op, n, EXwreg);
      end
      n++;
      tick();
    end
    n_checks++;
    if (n != 32) begin
      n_fail++;
      $display("FAIL mul_stall_len op=%0d got %0d want 32", op, n);
    end
    n_checks++;
    if ({EXaluResult, EXwreg} !== {want, 1'b1}) begin
      n_fail++;
      $display("FAIL mul_result op=%0d got res=%h wreg=%0b want %h 1", op, EXaluResult, EXwreg, want);
    end
  endtask

  task automatic test_flush();
    int n;
    set_op(4'd8, 1'b0, 1'b0, 32'd1234, 32'd5678, 32'd0, 1'b1, 1'b1, 1'b0, 5'd6);
    tick();
    n = 1;
    while (n < 10) begin
      tick();
      n++;
    end
    n_checks++;
    if (stall !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_pre_stall got %0b want 1", stall);
    end
    flush = 1'b1;
    set_op(4'd0, 1'b0, 1'b0, 32'd100, 32'd23, 32'd0, 1'b1, 1'b0, 1'b0, 5'd8);
    tick();
    flush = 1'b0;
    n_checks++;
    if ({stall, EXwreg, EXm2reg, EXwmem, EXwn, EXaluResult, EXdi} !== 72'd0) begin
      n_fail++;
      $display("FAIL flush_clear got stall=%0b wreg=%0b m2reg=%0b wn=%0d res=%h di=%h want all 0",
               stall, EXwreg, EXm2reg, EXwn, EXaluResult, EXdi);
    end
    tick();
    n_checks++;
    if ({EXaluResult, EXwreg, EXwn, stall} !== {32'd123, 1'b1, 5'd8, 1'b0}) begin
      n_fail++;
      $display("FAIL flush_next_add got res=%0d wreg=%0b wn=%0d stall=%0b want 123 1 8 0",
               EXaluResult, EXwreg, EXwn, stall);
    end
  endtask

  task automatic test_random();
    logic [3:0]  ops[12] = '{4'd0, 4'd4, 4'd1, 4'd5, 4'd2, 4'd6, 4'd3, 4'd7, 4'd15, 4'd8, 4'd12, 4'd9};
    logic [3:0]  op;
    logic [31:0] qa, qb, imm, a, b, exp_res;
    logic        sh, ai, wr, m2, wm;
    logic [4:0]  wn;
    int n, want_n;
    for (int i = 0; i < 40; i++) begin
      op  = ($urandom_range(0, 5) == 0) ? 4'($urandom) : ops[$urandom_range(0, 11)];
      qa  = $urandom; qb = $urandom; imm = $urandom;
      sh  = 1'($urandom_range(0, 1)); ai = 1'($urandom_range(0, 1));
      wr  = 1'($urandom_range(0, 1)); m2 = 1'($urandom_range(0, 1));
      wm  = 1'($urandom_range(0, 1)); wn = 5'($urandom);
      a   = sh ? (imm % 32) : qa;
      b   = ai ? imm : qb;
      exp_q.push_back(model(op, a, b));
      want_n = (op == 4'd8 || op == 4'd12) ? 32 : 0;
      set_op(op, sh, ai, qa, qb, imm, wr, m2, wm, wn);
      tick();
      n = 0;
      while (stall === 1'b1 && n < 100) begin
        n_checks++;
        if ({EXwreg, EXwmem} !== 2'b00) begin
          n_fail++;
          $display("FAIL rnd_we_during_stall i=%0d got wreg=%0b wmem=%0b want 0 0", i, EXwreg, EXwmem);
        end
        n++;
        tick();
      end
      n_checks++;
      if (n != want_n) begin
        n_fail++;
        $display("FAIL rnd_stall_len i=%0d op=%0d got %0d want %0d", i, op, n, want_n);
      end
      exp_res = exp_q.pop_front();
      n_checks++;
      if (EXaluResult !== exp_res) begin
        n_fail++;
        $display("FAIL rnd_result i=%0d op=%0d a=%h b=%h got %h want %h", i, op, a, b, EXaluResult, exp_res);
      end
      n_checks++;
      if ({EXwreg, EXm2reg, EXwmem, EXwn, EXdi} !== {wr, m2, wm, wn, qb}) begin
        n_fail++;
        $display("FAIL rnd_ctrl i=%0d got wreg=%0b m2reg=%0b wmem=%0b wn=%0d di=%h want %0b %0b %0b %0d %h",
                 i, EXwreg, EXm2reg, EXwmem, EXwn, EXdi, wr, m2, wm, wn, qb);
      end
    end
  endtask

  task automatic test_no_mul();
    int sum;
    n_aluc = 4'd8; n_shift = 1'b0; n_aluimm = 1'b0;
    n_qa = 16'($urandom_range(1, 65535)); n_qb = 16'($urandom_range(1, 65535));
    n_wreg = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if ({n_stall, n_res, n_exwreg} !== {1'b0, 16'd0, 1'b1}) begin
        n_fail++;
        $display("FAIL nomul_mullo cyc=%0d got stall=%0b res=%h wreg=%0b want 0 0000 1", i, n_stall, n_res, n_exwreg);
      end
    end
    n_aluc = 4'd0; n_qa = 16'hFFFF; n_qb = 16'd1;
    sum = (32'hFFFF + 1) % 65536;
    tick();
    n_checks++;
    if ({n_stall, n_res} !== {1'b0, 16'(sum)}) begin
      n_fail++;
      $display("FAIL nomul_add_wrap got stall=%0b res=%h want 0 %h", n_stall, n_res, 16'(sum));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_mux_shift();
    test_mul(4'd8, 32'h0001_0000);
    test_mul(4'd12, 32'h0000_0003);
    test_flush();
    test_random();
    test_no_mul();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
